ws2812_frame_scheduler: RTL
===========================

// Module: ws2812_frame_scheduler
// PURPOSE
//  Sequences frame updates for the 3-LED WS2812 serial driver. Accepts byte writes into a 9-byte shadow colour
//  store (UART command side), copies shadow->active on commit, then runs the start/ready handshake with the driver.
//  Active colours stay frozen for a whole frame, so the driver never shifts out a torn frame.
//  Sits between the UART command decoder and the WS2812 driver instance.
// PARAMETERS
//  CLOCK_FREQUENCY   100000000  system clock in Hz
//  REFRESH_HZ        30         auto-refresh rate (used only with WS2812_AUTO_REFRESH_EN)
//  START_TIMEOUT     4096       cycles to wait for driver ready to fall after start, before aborting
// PORTS
//  i_Clock             in   1   system clock, all logic on rising edge
//  i_Reset             in   1   asynchronous, active-high reset
//  i_Wr_Valid          in   1   write strobe, one byte per cycle, always accepted
//  i_Wr_Addr           in   4   0..8 = LED1 R,G,B, LED2 R,G,B, LED3 R,G,B; 9..15 ignored
//  i_Wr_Data           in   8   colour byte
//  i_Commit            in   1   request frame send (level sampled each cycle; pulse expected)
//  i_Drv_Ready         in   1   driver o_Ready (slow-clock domain; synchronised here)
//  o_Drv_Start         out  1   to driver i_Start
//  o_LED{1..3}_{R,G,B} out  8   active colour bytes, wired to driver colour inputs
//  o_Busy              out  1   high whenever state != IDLE or a commit is pending
//  o_Timeout           out  1   one-cycle pulse on start-handshake abort
// BEHAVIOUR
//  Reset: all shadow/active bytes 0, o_Drv_Start 0, o_Busy 0, o_Timeout 0, pending 0, state IDLE.
//  i_Drv_Ready passes through a 2-FF synchroniser (ready_s); 2-cycle latency. Reset value of both flops 0.
//  Shadow write: byte written on the edge where i_Wr_Valid=1; address >8 is a no-op. Writes are legal in any state.
//  pending: set by i_Commit (or refresh tick) in any state; cleared on IDLE->LATCH. Commits collapse to one frame.
//  FSM:
//   IDLE      : pending && ready_s -> LATCH. pending && !ready_s -> stay (driver still in its inter-frame gap).
//   LATCH     : one cycle; active <= shadow (write in same cycle lands in shadow only, sent next frame) -> START.
//   START     : o_Drv_Start=1; hold until ready_s==0 -> WAIT_DONE; counter reaching START_TIMEOUT-1 -> IDLE,
//               o_Drv_Start 0, o_Timeout pulse, pending left as is.
//   WAIT_DONE : o_Drv_Start=0; ready_s==1 -> IDLE. Active bytes must not change in START or WAIT_DONE.
//  o_Drv_Start is registered; it is 1 exactly while state==START. It must stay high across multiple driver bit
//  clocks because the driver samples start on its slow clock; the wait for ready to fall is the acknowledge.
//  Commit during START/WAIT_DONE: sets pending; next frame starts after return to IDLE (no frame dropped, at most
//  one queued).
//  Latency: i_Commit at cycle N, ready_s=1 -> LATCH at N+1, o_Drv_Start high at N+2.
//  Reset mid-frame: scheduler returns to IDLE immediately; driver shares i_Reset so both restart cleanly.
//  Timeout counter: log2(START_TIMEOUT) bits, cleared on entry to START; no wrap (saturates via exit).
// CONFIGURATION
//  WS2812_AUTO_REFRESH_EN defined: a free-running divider of CLOCK_FREQUENCY/REFRESH_HZ cycles asserts a
//   one-cycle tick that sets pending, so LEDs are re-sent periodically (recovers from line glitches).
//   Divider wraps to 0 at terminal count; reset value 0.
//  Not defined: divider absent; frames are sent only on i_Commit. Ports identical in both builds.
// STRUCTURE
//  ws2812_pkg: FSM state encodings (IDLE/LATCH/START/WAIT_DONE), LED_COUNT=3, BYTES_PER_LED=3,
//   FRAME_BYTES=9, address-map constants for each LED/colour byte.
//  One sub-module: ws2812_refresh_timer (divider + tick), instantiated only under WS2812_AUTO_REFRESH_EN.
//  Shadow and active stores are 9x8 register arrays in this module; colour outputs driven from active.
// TESTING
//  1 Write addr0=0xFF, addr4=0x80, addr8=0x11, commit with ready=1 -> o_LED1_R=FF, o_LED2_G=80, o_LED3_B=11
//    after LATCH; o_Drv_Start rises 2 cycles after commit.
//  2 Hold ready=1 for 100 cycles after start -> o_Drv_Start stays 1; drop ready -> start falls within 3 cycles.
//  3 During WAIT_DONE write addr0=0x00 and commit twice -> o_LED1_R stays FF until ready returns;
//    exactly one more frame follows with o_LED1_R=00.
//  4 Ready never falls after start (START_TIMEOUT=64) -> o_Timeout pulses once at cycle 64 of START; FSM IDLE.
//  5 Assert i_Reset mid-START -> o_Drv_Start, o_Busy, all o_LED bytes 0 asynchronously; writes to addr 9..15 ignored.
//  6 With WS2812_AUTO_REFRESH_EN, CLOCK_FREQUENCY=1000, REFRESH_HZ=10 -> a frame starts every 100 cycles, no commit.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 frame scheduler: FSM states, frame geometry and the colour byte address map.
package ws2812_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LATCH,
    ST_START,
    ST_WAIT_DONE
  } sched_state_t;

  localparam int LED_COUNT     = 3;
  localparam int BYTES_PER_LED = 3;
  localparam int FRAME_BYTES   = LED_COUNT * BYTES_PER_LED;

  localparam logic [3:0] ADDR_LED1_R = 4'd0;
  localparam logic [3:0] ADDR_LED1_G = 4'd1;
  localparam logic [3:0] ADDR_LED1_B = 4'd2;
  localparam logic [3:0] ADDR_LED2_R = 4'd3;
  localparam logic [3:0] ADDR_LED2_G = 4'd4;
  localparam logic [3:0] ADDR_LED2_B = 4'd5;
  localparam logic [3:0] ADDR_LED3_R = 4'd6;
  localparam logic [3:0] ADDR_LED3_G = 4'd7;
  localparam logic [3:0] ADDR_LED3_B = 4'd8;

  function automatic logic addr_in_frame(input logic [3:0] addr);
    return addr < 4'(FRAME_BYTES);
  endfunction

endpackage

// File: rtl/ws2812_refresh_timer.sv
// Free-running divider that emits a one-cycle tick every DIVIDE clocks, used to re-send the LED frame periodically.
module ws2812_refresh_timer #(
  parameter int unsigned DIVIDE = 3333333
) (
  input  logic i_Clock,
  input  logic i_Reset,
  output logic o_Tick
);

  localparam int unsigned COUNT_W = (DIVIDE > 2) ? $clog2(DIVIDE) : 1;
  localparam logic [COUNT_W-1:0] COUNT_LAST = COUNT_W'(DIVIDE - 1);

  logic [COUNT_W-1:0] div_count;

  assign o_Tick = (div_count == COUNT_LAST);

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      div_count <= '0;
    end else if (o_Tick) begin
      div_count <= '0;
    end else begin
      div_count <= div_count + 1'b1;
    end
  end

endmodule

// File: rtl/ws2812_frame_scheduler.sv
// Buffers colour writes in a shadow store and hands whole frames to the WS2812 driver via a start/ready handshake.
// Optional periodic re-send is enabled by defining WS2812_AUTO_REFRESH_EN.
module ws2812_frame_scheduler
  import ws2812_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 100000000,
  parameter int unsigned REFRESH_HZ      = 30,
  parameter int unsigned START_TIMEOUT   = 4096
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Wr_Valid,
  input  logic [3:0] i_Wr_Addr,
  input  logic [7:0] i_Wr_Data,
  input  logic       i_Commit,
  input  logic       i_Drv_Ready,
  output logic       o_Drv_Start,
  output logic [7:0] o_LED1_R,
  output logic [7:0] o_LED1_G,
  output logic [7:0] o_LED1_B,
  output logic [7:0] o_LED2_R,
  output logic [7:0] o_LED2_G,
  output logic [7:0] o_LED2_B,
  output logic [7:0] o_LED3_R,
  output logic [7:0] o_LED3_G,
  output logic [7:0] o_LED3_B,
  output logic       o_Busy,
  output logic       o_Timeout
);

  localparam int unsigned TIMEOUT_W = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(START_TIMEOUT - 1);

  if (REFRESH_HZ == 0 || REFRESH_HZ > CLOCK_FREQUENCY || START_TIMEOUT < 2) begin : g_bad_config
    $error("ws2812_frame_scheduler: invalid REFRESH_HZ/CLOCK_FREQUENCY/START_TIMEOUT");
  end

  sched_state_t         state, state_next;
  logic                 pending, pending_next;
  logic                 go_latch;
  logic                 timeout_hit;
  logic [TIMEOUT_W-1:0] timeout_count;
  logic                 ready_meta, ready_s;
  logic                 refresh_tick;
  logic                 frame_req;
  logic [7:0]           shadow [FRAME_BYTES];
  logic [7:0]           active [FRAME_BYTES];

  // Driver ready comes from the driver's slow clock domain
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      ready_meta <= 1'b0;
      ready_s    <= 1'b0;
    end else begin
      ready_meta <= i_Drv_Ready;
      ready_s    <= ready_meta;
    end
  end

`ifdef WS2812_AUTO_REFRESH_EN
  ws2812_refresh_timer #(
    .DIVIDE(CLOCK_FREQUENCY / REFRESH_HZ)
  ) u_refresh_timer (
    .i_Clock(i_Clock),
    .i_Reset(i_Reset),
    .o_Tick (refresh_tick)
  );
`else
  assign refresh_tick = 1'b0;
`endif

  assign frame_req = i_Commit | refresh_tick;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      for (int i = 0; i < FRAME_BYTES; i++) shadow[i] <= '0;
    end else if (i_Wr_Valid && addr_in_frame(i_Wr_Addr)) begin
      shadow[i_Wr_Addr] <= i_Wr_Data;
    end
  end

  // Active bytes only move in LATCH, so the driver always sees a consistent frame
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      for (int i = 0; i < FRAME_BYTES; i++) active[i] <= '0;
    end else if (state == ST_LATCH) begin
      for (int i = 0; i < FRAME_BYTES; i++) active[i] <= shadow[i];
    end
  end

  always_comb begin
    state_next  = state;
    go_latch    = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((pending || frame_req) && ready_s) begin
          state_next = ST_LATCH;
          go_latch   = 1'b1;
        end
      end
      ST_LATCH: state_next = ST_START;
      ST_START: begin
        if (!ready_s) begin
          state_next = ST_WAIT_DONE;
        end else if (timeout_count == TIMEOUT_LAST) begin
          state_next  = ST_IDLE;
          timeout_hit = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (ready_s) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // A request arriving on the IDLE->LATCH edge is covered by the frame being latched
    pending_next = pending;
    if (go_latch) begin
      pending_next = 1'b0;
    end else if (frame_req) begin
      pending_next = 1'b1;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state         <= ST_IDLE;
      pending       <= 1'b0;
      o_Drv_Start   <= 1'b0;
      o_Timeout     <= 1'b0;
      timeout_count <= '0;
    end else begin
      state         <= state_next;
      pending       <= pending_next;
      o_Drv_Start   <= (state_next == ST_START);
      o_Timeout     <= timeout_hit;
      timeout_count <= (state == ST_START) ? timeout_count + 1'b1 : '0;
    end
  end

  assign o_Busy = (state != ST_IDLE) || pending;

  assign o_LED1_R = active[ADDR_LED1_R];
  assign o_LED1_G = active[ADDR_LED1_G];
  assign o_LED1_B = active[ADDR_LED1_B];
  assign o_LED2_R = active[ADDR_LED2_R];
  assign o_LED2_G = active[ADDR_LED2_G];
  assign o_LED2_B = active[ADDR_LED2_B];
  assign o_LED3_R = active[ADDR_LED3_R];
  assign o_LED3_G = active[ADDR_LED3_G];
  assign o_LED3_B = active[ADDR_LED3_B];

endmodule
